stage_fetch: RTL
================

// Module: stage_fetch
// PURPOSE
//  Instruction-fetch stage: holds the architectural PC, drives instruction-memory address,
//  predicts branches with a direct-mapped BHT (2-bit counters) + BTB, and feeds the decode
//  stage's F-side inputs (instrF, pcF, pcPlus4F, bPredictedTakenF). Predictor is trained by
//  execute-stage branch resolution; mispredicts/jumps redirect the PC from execute.
// PARAMETERS
//  RESET_PC     32'h0000_0000  PC value loaded on reset (bits [1:0] must be 0)
//  BHT_ENTRIES  64             predictor entries, power of 2; IDX_W = $clog2(BHT_ENTRIES)
// PORTS
//  clk              in   1   clock, all state on rising edge
//  rst              in   1   asynchronous, active-low reset
//  stall            in   1   hold PC (hazard unit; same signal stalls the decode register)
//  redirect         in   1   execute-stage PC override (mispredict or jump)
//  redirectPc       in   32  target for redirect
//  updateEn         in   1   execute resolved a conditional branch/jump this cycle
//  updatePc         in   32  PC of the resolved instruction
//  updateTaken      in   1   resolved direction
//  updateTarget     in   32  resolved target address
//  imemAddr         out  32  instruction-memory address (= PC)
//  imemData         in   32  instruction word, combinational read of imemAddr
//  instrF           out  32  = imemData
//  pcF              out  32  current PC
//  pcPlus4F         out  32  PC + 4 (mod 2^32)
//  bPredictedTakenF out  1   prediction for the instruction at PC
// BEHAVIOUR
//  - Reset (rst=0, async): PC<=RESET_PC; all BHT counters <=2'b01 (weakly not-taken);
//    all BTB valid<=0. Outputs after reset: pcF=RESET_PC, pcPlus4F=RESET_PC+4,
//    bPredictedTakenF=0, imemAddr=RESET_PC. Reset mid-operation discards any in-flight update.
//  - Prediction (combinational, 0-cycle): idx=PC[IDX_W+1:2], tag=PC[31:IDX_W+2].
//    hit = valid[idx] & (btbTag[idx]==tag); bPredictedTakenF = hit & bht[idx][1].
//  - Next-PC priority (registered, 1 cycle): redirect -> {redirectPc[31:2],2'b00};
//    else stall -> hold; else bPredictedTakenF -> {btbTarget[idx][31:2],2'b00}; else PC+4.
//    redirect overrides stall in the same cycle.
//  - Training (on updateEn, independent of stall and redirect): uidx=updatePc[IDX_W+1:2];
//    counter saturates: taken -> min(c+1,3), not-taken -> max(c-1,0).
//    If updateTaken: btbTag[uidx]<=updatePc tag, btbTarget[uidx]<=updateTarget, valid<=1.
//    Not-taken updates leave BTB untouched.
//  - Same-cycle read/write of one index: prediction uses pre-update state (read-before-write).
//  - PC+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000; no exception generated here.
//  - Decode-register flush on redirect is the hazard unit's job, not this block's.
// STRUCTURE
//  - Shared package core_pkg: RESET_PC default, typedef logic [1:0] bht_ctr_t,
//    constants CTR_SNT=0, CTR_WNT=1, CTR_WT=2, CTR_ST=3.
//  - One sub-module: branch_predictor (BHT+BTB arrays, lookup port, update port);
//    stage_fetch keeps PC register and next-PC mux.
// TESTING
//  1. Assert rst=0 mid-run with PC=0x40 -> PC=RESET_PC immediately (async), prediction=0.
//  2. No branches, stall=0, 4 cycles -> pcF 0x0,0x4,0x8,0xC; pcPlus4F tracks +4.
//  3. updateEn, updatePc=0x10, updateTaken=1, updateTarget=0x00, twice -> fetch at 0x10
//     gives bPredictedTakenF=1, next pcF=0x00 (counter 01->10->11).
//  4. stall=1 and redirect=1, redirectPc=0x123 same cycle -> next pcF=0x120.
//  5. Counter at 3, two more taken updates -> stays 3; then 3 not-taken -> 0, prediction 0.
//  6. Train 0x10 taken; fetch alias 0x10+4*BHT_ENTRIES -> tag miss, bPredictedTakenF=0,
//     next PC = alias+4.

Source files
------------

// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Shared types and constants for the fetch stage and its
//               branch predictor: default reset PC, 2-bit saturating
//               counter type/encodings and the counter update helper.
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef logic [1:0] bht_ctr_t;

    localparam bht_ctr_t CTR_SNT = 2'd0;  // strongly not-taken
    localparam bht_ctr_t CTR_WNT = 2'd1;  // weakly not-taken
    localparam bht_ctr_t CTR_WT  = 2'd2;  // weakly taken
    localparam bht_ctr_t CTR_ST  = 2'd3;  // strongly taken

    // Saturating 2-bit counter step
    function automatic bht_ctr_t ctr_next(input bht_ctr_t ctr, input logic taken);
        bht_ctr_t nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != CTR_ST) begin
                nxt = ctr + 2'd1;
            end
        end else begin
            if (ctr != CTR_SNT) begin
                nxt = ctr - 2'd1;
            end
        end
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor
// Description : Direct-mapped branch history table (2-bit counters) plus
//               branch target buffer. Combinational lookup port returns the
//               taken prediction and target for a word-aligned PC; the update
//               port trains one entry per cycle from execute-stage resolution.
// Ports       : clk, rst (async, active-low)
//               lookup_pc[31:2]   -> pred_taken, pred_target[31:2]
//               update_en, update_pc[31:2], update_taken, update_target[31:2]
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor
    import core_pkg::*;
#(
    parameter int BHT_ENTRIES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:2] lookup_pc,
    output logic        pred_taken,
    output logic [31:2] pred_target,
    input  logic        update_en,
    input  logic [31:2] update_pc,
    input  logic        update_taken,
    input  logic [31:2] update_target
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    bht_ctr_t          bht        [BHT_ENTRIES];
    logic              btb_valid  [BHT_ENTRIES];
    logic [TAG_W-1:0]  btb_tag    [BHT_ENTRIES];
    logic [31:2]       btb_target [BHT_ENTRIES];

    logic [IDX_W-1:0]  lidx;
    logic [TAG_W-1:0]  ltag;
    logic [IDX_W-1:0]  uidx;
    logic [TAG_W-1:0]  utag;
    logic              lhit;

    assign lidx = lookup_pc[IDX_W+1:2];
    assign ltag = lookup_pc[31:IDX_W+2];
    assign uidx = update_pc[IDX_W+1:2];
    assign utag = update_pc[31:IDX_W+2];

    // Reads see the array contents before this cycle's update lands
    assign lhit        = btb_valid[lidx] && (btb_tag[lidx] == ltag);
    assign pred_taken  = lhit && bht[lidx][1];
    assign pred_target = btb_target[lidx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i]       <= CTR_WNT;
                btb_valid[i] <= 1'b0;
            end
        end else if (update_en) begin
            bht[uidx] <= ctr_next(bht[uidx], update_taken);
            if (update_taken) begin
                btb_valid[uidx] <= 1'b1;
            end
        end
    end

    // Tag/target need no reset since the valid bit qualifies them; the rst
    // term drops any update presented while reset is held.
    always_ff @(posedge clk) begin
        if (rst && update_en && update_taken) begin
            btb_tag[uidx]    <= utag;
            btb_target[uidx] <= update_target;
        end
    end

endmodule
`default_nettype wire

// File: rtl/stage_fetch.sv
`default_nettype none
// ============================================================================
// Module      : stage_fetch
// Description : Instruction-fetch stage. Holds the architectural PC, drives
//               the instruction-memory address, predicts branches through
//               branch_predictor and selects the next PC.
// Ports       : clk, rst (async, active-low), stall, redirect, redirectPc,
//               updateEn/updatePc/updateTaken/updateTarget (predictor training),
//               imemAddr/imemData (instruction memory),
//               instrF, pcF, pcPlus4F, bPredictedTakenF (to decode)
// Revision    : 1.0 - initial release
// ============================================================================
module stage_fetch
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int          BHT_ENTRIES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirectPc,
    input  logic        updateEn,
    input  logic [31:0] updatePc,
    input  logic        updateTaken,
    input  logic [31:0] updateTarget,
    output logic [31:0] imemAddr,
    input  logic [31:0] imemData,
    output logic [31:0] instrF,
    output logic [31:0] pcF,
    output logic [31:0] pcPlus4F,
    output logic        bPredictedTakenF
);

    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] pc_plus4;
    logic        pred_taken;
    logic [31:2] pred_target;
    logic        unused_low_bits;

    // Byte-offset bits of incoming addresses carry no information here
    assign unused_low_bits = ^{redirectPc[1:0], updatePc[1:0], updateTarget[1:0]};

    branch_predictor #(
        .BHT_ENTRIES (BHT_ENTRIES)
    ) u_bp (
        .clk           (clk),
        .rst           (rst),
        .lookup_pc     (pc[31:2]),
        .pred_taken    (pred_taken),
        .pred_target   (pred_target),
        .update_en     (updateEn),
        .update_pc     (updatePc[31:2]),
        .update_taken  (updateTaken),
        .update_target (updateTarget[31:2])
    );

    assign pc_plus4 = pc + 32'd4;  // wraps naturally at 2^32

    // Redirect wins over stall so an execute-stage correction is never lost
    always_comb begin
        pc_next = pc_plus4;
        if (redirect) begin
            pc_next = {redirectPc[31:2], 2'b00};
        end else if (stall) begin
            pc_next = pc;
        end else if (pred_taken) begin
            pc_next = {pred_target, 2'b00};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= {RESET_PC[31:2], 2'b00};
        end else begin
            pc <= pc_next;
        end
    end

    assign imemAddr         = pc;
    assign instrF           = imemData;
    assign pcF              = pc;
    assign pcPlus4F         = pc_plus4;
    assign bPredictedTakenF = pred_taken;

endmodule
`default_nettype wire
